// File: rtl/prog_imem_pkg.sv
// Shared types and constants for the program instruction memory.
package prog_imem_pkg;

    // Load/run control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Instruction returned for any fetch that cannot be served from memory.
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h6800_0000;

    // Width of a counter that must reach DEPTH itself (0..DEPTH inclusive).
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port instruction storage: synchronous write, registered read, no reset.
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write on we, read the addressed word every cycle into the output register.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/prog_imem.sv
// Loadable program memory: a streamed load fills the RAM, then single-cycle
// latency fetches are served, with bad fetches answered by a NOP and an error.
module prog_imem
    import prog_imem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEFAULT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld_start,
    input  logic                      ld_valid,
    input  logic [DATA_W-1:0]         ld_data,
    input  logic                      ld_last,
    output logic                      ld_ready,
    output logic [count_w(DEPTH)-1:0] ld_count,
    output logic                      ld_ovf,
    input  logic                      fetch_req,
    input  logic [ADDR_W-1:0]         fetch_addr,
    output logic                      fetch_ready,
    output logic                      inst_valid,
    output logic [DATA_W-1:0]         inst,
    output logic                      fetch_err
);

    localparam int CW = count_w(DEPTH);
    localparam int AW = $clog2(DEPTH);

    state_t            state_reg;
    state_t            state_next;
    logic [CW-1:0]     wptr_reg;
    logic              ovf_reg;
    logic              inst_valid_reg;
    logic              fetch_err_reg;
    logic [DATA_W-1:0] inst_hold_reg;

    logic              beat;
    logic              fetch_acc;
    logic              wptr_full;
    logic [ADDR_W-1:0] fetch_index;
    logic              fetch_ok;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    // A restart request wins over any load beat or fetch in the same cycle.
    assign beat      = ld_valid && (state_reg == LOAD) && !ld_start;
    assign fetch_acc = fetch_req && (state_reg == RUN) && !ld_start;
    assign wptr_full = (wptr_reg == CW'(DEPTH));

    // Words are loaded contiguously from 0, so the write pointer is the count.
    assign ld_count = wptr_reg;
    assign ld_ovf   = ovf_reg;

    assign fetch_index = fetch_addr >> 2;
    assign fetch_ok    = (fetch_addr[1:0] == 2'b00)
                      && (fetch_index < ADDR_W'(DEPTH))
                      && (fetch_index < ADDR_W'(wptr_reg));

    // Loads and fetches never overlap in time, so one RAM port serves both.
    assign ram_we   = beat && !wptr_full;
    assign ram_addr = (state_reg == LOAD) ? wptr_reg[AW-1:0] : fetch_addr[AW+1:2];

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ld_data),
        .rdata (ram_rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next  = state_reg;
        ld_ready    = 1'b0;
        fetch_ready = 1'b0;
        case (state_reg)
            IDLE: ;
            LOAD: begin
                ld_ready = 1'b1;
                if (beat && ld_last) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                fetch_ready = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        if (ld_start) begin
            state_next = LOAD;
        end
    end

    // Write pointer and sticky overflow: saturate at DEPTH, flag dropped beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg <= '0;
            ovf_reg  <= 1'b0;
        end else if (ld_start) begin
            wptr_reg <= '0;
            ovf_reg  <= 1'b0;
        end else if (beat) begin
            if (wptr_full) begin
                ovf_reg <= 1'b1;
            end else begin
                wptr_reg <= wptr_reg + 1'b1;
            end
        end
    end

    // Fetch response tracking, one cycle behind acceptance, plus a held copy of inst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_valid_reg <= 1'b0;
            fetch_err_reg  <= 1'b0;
            inst_hold_reg  <= '0;
        end else begin
            inst_valid_reg <= fetch_acc;
            fetch_err_reg  <= fetch_acc && !fetch_ok;
            if (inst_valid_reg) begin
                inst_hold_reg <= inst;
            end
        end
    end

    assign inst_valid = inst_valid_reg;
    assign fetch_err  = fetch_err_reg;
    assign inst       = inst_valid_reg ? (fetch_err_reg ? NOP_INST : ram_rdata) : inst_hold_reg;

endmodule
